// File: rtl/cache_line_refill_pkg.sv
// Shared types and address-field helpers for the cache line refill stage.
package cache_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned TAG_W          = 24;
    localparam int unsigned SET_W          = 4;
    localparam int unsigned OFFS_W         = 2;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned LINE_W         = WORDS_PER_LINE * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } refill_state_t;

    // Byte address split into cache fields, MSB first.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SET_W-1:0]  set_idx;
        logic [OFFS_W-1:0] offs;
        logic [1:0]        byte_offs;
    } addr_t;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [TAG_W-1:0]  tag,
        input logic [SET_W-1:0]  set_idx,
        input logic [OFFS_W-1:0] offs
    );
        return {tag, set_idx, offs, 2'b00};
    endfunction

endpackage

// File: rtl/cache_line_refill_assembler.sv
// Line buffer: one word written per cycle at a 2-bit index, cleared on reset.
module line_assembler
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 we_i,
    input  logic [OFFS_W-1:0]                    idx_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_o
);

    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else begin
            for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
                if (we_i && (idx_i == OFFS_W'(i))) begin
                    words_q[i] <= wdata_i;
                end
            end
        end
    end

    assign line_o = words_q;

endmodule

// File: rtl/cache_line_refill.sv
// Cache miss refill: fetches a 4-word line critical-word-first with wrap,
// pulses the critical word early and the whole line once assembled.
module cache_line_refill
    import cache_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 miss_req,
    input  logic [ADDRESS_WIDTH-1:0]             miss_addr,
    output logic                                 stall,
    output logic                                 mem_req,
    output logic [ADDRESS_WIDTH-1:0]             mem_addr,
    input  logic                                 mem_ack,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic                                 crit_valid,
    output logic [DATA_WIDTH-1:0]                crit_word,
    output logic                                 line_valid,
    output logic [SET_W-1:0]                     line_set,
    output logic [TAG_W-1:0]                     line_tag,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_data
);

    if (WORDS_PER_LINE != cache_pkg::WORDS_PER_LINE ||
        ADDRESS_WIDTH != ADDR_W || DATA_WIDTH != WORD_W) begin : g_cfg_check
        $error("cache_line_refill: only a 32-bit address, 32-bit word, 4-word line is supported");
    end

    refill_state_t           state_q;
    logic [OFFS_W-1:0]       beat_q;
    logic [OFFS_W-1:0]       beat_d;
    logic [OFFS_W-1:0]       offs_q;
    logic [TAG_W-1:0]        tag_q;
    logic [SET_W-1:0]        set_q;
    logic                    mem_req_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic                    crit_valid_q;
    logic [DATA_WIDTH-1:0]   crit_word_q;
    logic                    line_valid_q;

    addr_t                   miss_f;
    logic                    unused_byte_offs;
    logic                    beat_fire;
    logic [OFFS_W-1:0]       wr_idx;

    assign miss_f           = addr_t'(miss_addr);
    assign unused_byte_offs = ^miss_f.byte_offs;

    // Acks are only meaningful while a request is outstanding.
    assign beat_fire = (state_q == FETCH) && mem_ack;
    assign beat_d    = beat_q + 2'd1;
    assign wr_idx    = offs_q + beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            offs_q       <= '0;
            tag_q        <= '0;
            set_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            crit_valid_q <= 1'b0;
            crit_word_q  <= '0;
            line_valid_q <= 1'b0;
        end else begin
            crit_valid_q <= 1'b0;
            line_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_req) begin
                        state_q    <= FETCH;
                        beat_q     <= '0;
                        offs_q     <= miss_f.offs;
                        tag_q      <= miss_f.tag;
                        set_q      <= miss_f.set_idx;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= word_addr(miss_f.tag, miss_f.set_idx, miss_f.offs);
                    end
                end
                FETCH: begin
                    if (beat_fire) begin
                        beat_q <= beat_d;
                        if (beat_q == '0) begin
                            crit_word_q  <= mem_rdata;
                            crit_valid_q <= 1'b1;
                        end
                        // Last beat: request drops and the line pulse is raised together.
                        if (beat_q == 2'd3) begin
                            state_q      <= DONE;
                            mem_req_q    <= 1'b0;
                            line_valid_q <= 1'b1;
                        end else begin
                            mem_addr_q <= word_addr(tag_q, set_q, offs_q + beat_d);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    line_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (beat_fire),
        .idx_i   (wr_idx),
        .wdata_i (mem_rdata),
        .line_o  (line_data)
    );

    assign stall      = (state_q != IDLE) || miss_req;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign crit_valid = crit_valid_q;
    assign crit_word  = crit_word_q;
    assign line_valid = line_valid_q;
    assign line_set   = set_q;
    assign line_tag   = tag_q;

endmodule
